// File: rtl/pulse_level_pkg.sv
// Shared mode encodings and sizing helper for the multi-channel pulse-to-level converter.
package pulse_level_pkg;

  localparam int MODE_TOGGLE    = 0;
  localparam int MODE_SET_CLEAR = 1;
  localparam int MODE_STRETCH   = 2;

  // Stretch down-counter width; never narrower than one bit.
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_level_channel.sv
// One channel: optional synchroniser, rising-edge detect, mode logic and stretch counter.
module pulse_level_channel
  import pulse_level_pkg::*;
#(
  parameter int MODE        = MODE_SET_CLEAR,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_LEN = 8
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Pulse,
  input  logic i_Stop,
  input  logic i_Clear,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Overrun
);

  localparam int CW = cnt_width(STRETCH_LEN);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_LEN - 1);

  logic pulse_s, stop_s, ready;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;
    logic [SYNC_STAGES-1:0] stop_sync_q, stop_sync_d;
    logic [SYNC_STAGES-1:0] warm_q, warm_d;

    always_comb begin
      pulse_sync_d = (pulse_sync_q << 1) | SYNC_STAGES'(i_Pulse);
      stop_sync_d  = (stop_sync_q << 1) | SYNC_STAGES'(i_Stop);
      warm_d       = (warm_q << 1) | SYNC_STAGES'(1'b1);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        pulse_sync_q <= '0;
        stop_sync_q  <= '0;
        warm_q       <= '0;
      end else begin
        pulse_sync_q <= pulse_sync_d;
        stop_sync_q  <= stop_sync_d;
        warm_q       <= warm_d;
      end
    end

    assign pulse_s = pulse_sync_q[SYNC_STAGES-1];
    assign stop_s  = stop_sync_q[SYNC_STAGES-1];
    // Synchroniser output is only the reset zero until it has filled; the
    // previous-value registers keep their reset 1 until then, so an input
    // already high at reset release never looks like a fresh edge.
    assign ready   = warm_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign pulse_s = i_Pulse;
    assign stop_s  = i_Stop;
    assign ready   = 1'b1;
  end

  logic          prev_pulse_q, prev_pulse_d;
  logic          prev_stop_q, prev_stop_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_evt, p_evt;

  assign s_evt = pulse_s & ~prev_pulse_q;
  assign p_evt = stop_s & ~prev_stop_q & (MODE == MODE_SET_CLEAR);

  always_comb begin
    prev_pulse_d = ready ? pulse_s : prev_pulse_q;
    prev_stop_d  = ready ? stop_s : prev_stop_q;
    level_d      = level_q;
    ovr_d        = ovr_q;
    cnt_d        = cnt_q;

    case (MODE)
      MODE_TOGGLE: begin
        if (s_evt) level_d = ~level_q;
      end
      MODE_SET_CLEAR: begin
        if (s_evt && p_evt) begin
          // Zero-width window when idle; when open, the stop wins and the extra start is flagged.
          if (level_q) begin
            level_d = 1'b0;
            ovr_d   = 1'b1;
          end
        end else if (s_evt) begin
          if (level_q) ovr_d   = 1'b1;
          else         level_d = 1'b1;
        end else if (p_evt) begin
          level_d = 1'b0;
        end
      end
      MODE_STRETCH: begin
        if (s_evt) begin
          cnt_d   = RELOAD;
          level_d = 1'b1;
          if (level_q) ovr_d = 1'b1;
        end else if (level_q) begin
          if (cnt_q == '0) level_d = 1'b0;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (i_Clear) begin
      level_d = 1'b0;
      ovr_d   = 1'b0;
      cnt_d   = '0;
    end

    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q & ~i_Clear;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      prev_pulse_q <= 1'b1;
      prev_stop_q  <= 1'b1;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      ovr_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      prev_pulse_q <= prev_pulse_d;
      prev_stop_q  <= prev_stop_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      ovr_q        <= ovr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_Level   = level_q;
  assign o_Rise    = rise_q;
  assign o_Fall    = fall_q;
  assign o_Overrun = ovr_q;

endmodule

// File: rtl/pulse_to_level_mc.sv
// Multi-channel pulse-to-level converter: CHANNELS independent lanes sharing clock, reset and soft clear.
module pulse_to_level_mc
  import pulse_level_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int MODE        = MODE_SET_CLEAR,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_LEN = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [CHANNELS-1:0] i_Pulse,
  input  logic [CHANNELS-1:0] i_Stop,
  input  logic                i_Clear,
  output logic [CHANNELS-1:0] o_Level,
  output logic [CHANNELS-1:0] o_Rise,
  output logic [CHANNELS-1:0] o_Fall,
  output logic [CHANNELS-1:0] o_Overrun
);

  if (MODE < MODE_TOGGLE || MODE > MODE_STRETCH) begin : g_bad_mode
    $error("pulse_to_level_mc: illegal MODE %0d", MODE);
  end
  if (STRETCH_LEN < 1 || STRETCH_LEN > 65536) begin : g_bad_len
    $error("pulse_to_level_mc: illegal STRETCH_LEN %0d", STRETCH_LEN);
  end
  if (SYNC_STAGES == 1 || SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("pulse_to_level_mc: illegal SYNC_STAGES %0d", SYNC_STAGES);
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_ch
    $error("pulse_to_level_mc: illegal CHANNELS %0d", CHANNELS);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_level_channel #(
      .MODE        (MODE),
      .SYNC_STAGES (SYNC_STAGES),
      .STRETCH_LEN (STRETCH_LEN)
    ) u_ch (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Pulse   (i_Pulse[g]),
      .i_Stop    (i_Stop[g]),
      .i_Clear   (i_Clear),
      .o_Level   (o_Level[g]),
      .o_Rise    (o_Rise[g]),
      .o_Fall    (o_Fall[g]),
      .o_Overrun (o_Overrun[g])
    );
  end

endmodule

// File: tb/tb_pulse_to_level_mc.sv
// Scoreboard bench: four instances (toggle, set/clear, stretch, synchronised set/clear) checked per cycle.
module tb_pulse_to_level_mc;

  logic       clk, rst, clear;
  logic [3:0] pul [4];
  logic [3:0] stp [4];
  logic [3:0] lvl [4];
  logic [3:0] ris [4];
  logic [3:0] fal [4];
  logic [3:0] ovr [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int       d;
    logic [3:0] l, r, f, o;
    string    nm;
  } ent_t;

  ent_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pulse_to_level_mc #(.CHANNELS(4), .MODE(0), .SYNC_STAGES(0), .STRETCH_LEN(8)) dut_tg (
    .i_Clk(clk), .i_Rst(rst), .i_Pulse(pul[0]), .i_Stop(stp[0]), .i_Clear(clear),
    .o_Level(lvl[0]), .o_Rise(ris[0]), .o_Fall(fal[0]), .o_Overrun(ovr[0]));
  pulse_to_level_mc #(.CHANNELS(4), .MODE(1), .SYNC_STAGES(0), .STRETCH_LEN(8)) dut_sc (
    .i_Clk(clk), .i_Rst(rst), .i_Pulse(pul[1]), .i_Stop(stp[1]), .i_Clear(clear),
    .o_Level(lvl[1]), .o_Rise(ris[1]), .o_Fall(fal[1]), .o_Overrun(ovr[1]));
  pulse_to_level_mc #(.CHANNELS(4), .MODE(2), .SYNC_STAGES(0), .STRETCH_LEN(8)) dut_st (
    .i_Clk(clk), .i_Rst(rst), .i_Pulse(pul[2]), .i_Stop(stp[2]), .i_Clear(clear),
    .o_Level(lvl[2]), .o_Rise(ris[2]), .o_Fall(fal[2]), .o_Overrun(ovr[2]));
  pulse_to_level_mc #(.CHANNELS(4), .MODE(1), .SYNC_STAGES(2), .STRETCH_LEN(8)) dut_sy (
    .i_Clk(clk), .i_Rst(rst), .i_Pulse(pul[3]), .i_Stop(stp[3]), .i_Clear(clear),
    .o_Level(lvl[3]), .o_Rise(ris[3]), .o_Fall(fal[3]), .o_Overrun(ovr[3]));

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got(l,r,f,o)=%h required=%h", nm, got, exp);
    end
  endtask

  // Drive one cycle of stimulus on instance d; expectation is the output after the next edge.
  task automatic cyc(input int d, input logic [3:0] p, input logic [3:0] s, input logic clr,
                     input logic [3:0] el, input logic [3:0] er, input logic [3:0] ef,
                     input logic [3:0] eo, input string nm);
    ent_t e;
    @(negedge clk);
    pul[d] = p;
    stp[d] = s;
    clear  = clr;
    e.d = d; e.l = el; e.r = er; e.f = ef; e.o = eo; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry retires per clock, sampled just after the edge.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, {lvl[e.d], ris[e.d], fal[e.d], ovr[e.d]}, {e.l, e.r, e.f, e.o});
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pul[i] = 4'h0;
      stp[i] = 4'h0;
    end
    pul[3] = 4'b0001;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) cyc(d, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "reset_state");
    for (int i = 0; i < 6; i++) cyc(3, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "held_thru_reset");

    // Synchronised instance: latency of two edges
    for (int i = 0; i < 3; i++) cyc(3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sync_idle");
    cyc(3, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sync_lat0");
    cyc(3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sync_lat1");
    cyc(3, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "sync_lat2");
    cyc(3, 4'h0, 4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "sync_stop0");
    cyc(3, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "sync_stop1");
    cyc(3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, "sync_stop2");
    cyc(3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sync_after");

    // Toggle: three single-cycle pulses on ch0, stop ignored
    cyc(0, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "tg_p1");
    cyc(0, 4'h0, 4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "tg_stop_ign");
    cyc(0, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, "tg_p2");
    cyc(0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "tg_gap");
    cyc(0, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "tg_p3");
    cyc(0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "tg_hold");
    cyc(0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "clear_no_fall");
    cyc(0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "tg_idle");

    // Set/clear: 37-cycle window
    cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "sc_start");
    for (int i = 0; i < 36; i++) cyc(1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "sc_window");
    cyc(1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, "sc_stop");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sc_idle");
    cyc(1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sc_stop_low_ign");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sc_idle");

    // Wide start counts once
    cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "sc_wide0");
    for (int i = 0; i < 4; i++) cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "sc_wide_hold");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "sc_wide_end");
    cyc(1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, "sc_wide_stop");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sc_idle");

    // Second start while high: sticky overrun until clear
    cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "ov_start");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "ov_gap");
    cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h1, "ov_second");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h1, "ov_hold");
    cyc(1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, "ov_stop");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, "ov_sticky");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, "ov_sticky");
    cyc(1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "ov_cleared");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sc_idle");

    // Simultaneous start and stop
    cyc(1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sp_low");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "sp_low_after");
    cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "sp_open");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "sp_gap");
    cyc(1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, "sp_high");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, "sp_high_after");
    cyc(1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "sp_cleared");

    // Stretch: single pulse high exactly 8 cycles
    cyc(2, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "st_start");
    for (int i = 0; i < 7; i++) cyc(2, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "st_high");
    cyc(2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, "st_fall");
    cyc(2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "st_idle");

    // Stretch retrigger at cycle 5: 13 cycles high
    cyc(2, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "rt_start");
    for (int i = 0; i < 4; i++) cyc(2, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "rt_high");
    cyc(2, 4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h1, "rt_retrig");
    for (int i = 0; i < 7; i++) cyc(2, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h1, "rt_high2");
    cyc(2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, "rt_fall");
    cyc(2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, "rt_sticky");
    cyc(2, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "rt_cleared");

    // Async reset mid-window
    cyc(1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, "ar_start");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, "ar_open");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {lvl[1], ris[1], fal[1], ovr[1]}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "post_rst");

    // Clear coincident with start discards it
    cyc(1, 4'h1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "clr_with_s");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "clr_after");
    cyc(1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "clr_after");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d entries left required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
